bus_rr_arbiter: RTL

Synthesizable single-bus arbiter and packet router for the multi-device bus environment.
- Arbitrates among DRVRS device FIFOs and pops one packet per transaction.
- Decodes the destination ID in the packet header.
- Delivers the packet to one device, or to all other devices on broadcast.
- Over the previous generation it adds: selectable round-robin/fixed priority, receiver backpressure (full), drop of invalid or self-addressed packets, and status counters.

---
 rtl/bus_arb_pkg.sv | 37 +++
 rtl/bus_rr_arbiter_rr_picker.sv | 36 +++
 rtl/bus_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the single-bus arbiter/router family.
// Holds the transaction FSM encoding, header extraction and the broadcast ID default.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    DECODE  = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam int MAX_PKT_W = 64;
  localparam int MAX_ID_W  = 16;

  localparam logic [MAX_ID_W-1:0] BROADCAST_DEF = {MAX_ID_W{1'b1}};

  // Top id_w bits of a pkt_w-wide packet, zero-extended to MAX_ID_W.
  function automatic logic [MAX_ID_W-1:0] hdr_dest(
    input logic [MAX_PKT_W-1:0] pkt,
    input int                   pkt_w,
    input int                   id_w
  );
    logic [MAX_PKT_W-1:0] sh;
    logic [MAX_ID_W-1:0]  res;
    sh  = pkt >> (pkt_w - id_w);
    res = '0;
    for (int b = 0; b < MAX_ID_W; b++) begin
      if (b < id_w) begin
        res[b] = sh[b];
      end else begin
        res[b] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_picker.sv
// Combinational requester picker: round-robin search from ptr (MODE 0)
// or lowest-index-wins fixed priority (MODE 1).
module rr_picker #(
  parameter int DRVRS = 4,
  parameter int MODE  = 0
) (
  input  logic [DRVRS-1:0]         req,
  input  logic [$clog2(DRVRS)-1:0] ptr,
  output logic [$clog2(DRVRS)-1:0] gnt_idx,
  output logic                     gnt_valid
);

  localparam int IDX_W = $clog2(DRVRS);

  // First set request in search order wins
  always_comb begin : pick
    int idx_v;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx_v     = 0;
    for (int k = 0; k < DRVRS; k++) begin
      if (MODE == 1) begin
        idx_v = k;
      end else begin
        idx_v = (int'(ptr) + k) % DRVRS;
      end
      if (!gnt_valid && req[idx_v]) begin
        gnt_idx   = IDX_W'(idx_v);
        gnt_valid = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Single-bus arbiter/router: pops one packet from the winning device FIFO,
// decodes its destination and delivers it (unicast or broadcast) or drops it.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = ID_W'(BROADCAST_DEF),
  parameter int              MODE      = 0,
  parameter int              CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic                       busy,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int IDX_W = $clog2(DRVRS);

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [IDX_W-1:0]           grant_r;
  logic [IDX_W-1:0]           rr_ptr_r;
  logic [PCKG_SZ-1:0]         pkt_q_r;
  logic [DRVRS-1:0]           mask_r;
  logic [DRVRS-1:0]           pop_r;
  logic [DRVRS-1:0]           push_r;
  logic [DRVRS*PCKG_SZ-1:0]   d_push_r;
  logic                       busy_r;
  logic [CNT_W-1:0]           pkt_cnt_r;
  logic [CNT_W-1:0]           drop_cnt_r;

  logic [IDX_W-1:0]           pick_idx_s;
  logic                       pick_valid_s;
  logic [IDX_W-1:0]           ptr_next_s;
  logic [PCKG_SZ-1:0]         pop_data_s;
  logic [MAX_ID_W-1:0]        dest_s;
  logic [DRVRS-1:0]           mask_s;
  logic                       drop_s;
  logic                       fire_s;
  logic [DRVRS-1:0]           fire_mask_s;

  rr_picker #(
    .DRVRS (DRVRS),
    .MODE  (MODE)
  ) u_picker (
    .req       (pndng),
    .ptr       (rr_ptr_r),
    .gnt_idx   (pick_idx_s),
    .gnt_valid (pick_valid_s)
  );

  assign ptr_next_s = (pick_idx_s == IDX_W'(DRVRS - 1)) ? '0 : pick_idx_s + IDX_W'(1);
  assign pop_data_s = D_pop[int'(grant_r)*PCKG_SZ +: PCKG_SZ];
  assign dest_s     = hdr_dest(MAX_PKT_W'(pkt_q_r), PCKG_SZ, ID_W);

  // Destination decode into a receiver mask, or a drop for bad/self addresses
  always_comb begin
    mask_s = '0;
    drop_s = 1'b0;
    if (dest_s == MAX_ID_W'(BROADCAST)) begin
      mask_s = ~(DRVRS'(1) << grant_r);
    end else if ((dest_s < MAX_ID_W'(DRVRS)) && (dest_s != MAX_ID_W'(grant_r))) begin
      mask_s = DRVRS'(1) << dest_s;
    end else begin
      drop_s = 1'b1;
    end
  end

  // Delivery fires as soon as every addressed receiver can accept
  always_comb begin
    fire_s      = 1'b0;
    fire_mask_s = '0;
    case (state_r)
      DECODE: begin
        if (!drop_s && ((full & mask_s) == '0)) begin
          fire_s      = 1'b1;
          fire_mask_s = mask_s;
        end else begin
          fire_s = 1'b0;
        end
      end
      DELIVER: begin
        if ((push_r == '0) && ((full & mask_r) == '0)) begin
          fire_s      = 1'b1;
          fire_mask_s = mask_r;
        end else begin
          fire_s = 1'b0;
        end
      end
      default: fire_s = 1'b0;
    endcase
  end

  // Next-state logic; DELIVER is left the cycle after the push strobe is shown
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = POP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      POP:    state_nxt_s = DECODE;
      DECODE: begin
        if (drop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DELIVER;
        end
      end
      DELIVER: begin
        if (push_r != '0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DELIVER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Transaction datapath: grant latch, packet capture, strobes, saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      pkt_q_r    <= '0;
      mask_r     <= '0;
      pop_r      <= '0;
      push_r     <= '0;
      d_push_r   <= '0;
      pkt_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      pop_r  <= '0;
      push_r <= '0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_idx_s;
            pop_r   <= DRVRS'(1) << pick_idx_s;
            if (MODE == 0) begin
              rr_ptr_r <= ptr_next_s;
            end
          end
        end
        POP:    pkt_q_r <= pop_data_s;
        DECODE: begin
          if (drop_s) begin
            if (drop_cnt_r != {CNT_W{1'b1}}) begin
              drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
          end else begin
            mask_r <= mask_s;
          end
        end
        default: mask_r <= mask_r;
      endcase
      if (fire_s) begin
        push_r   <= fire_mask_s;
        d_push_r <= {DRVRS{pkt_q_r}};
        if (pkt_cnt_r != {CNT_W{1'b1}}) begin
          pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign pop      = pop_r;
  assign push     = push_r;
  assign D_push   = d_push_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;
  assign pkt_cnt  = pkt_cnt_r;
  assign drop_cnt = drop_cnt_r;

endmodule
